// File: rtl/nes_multi_poller.sv
`timescale 1ns/1ps
// nes_multi_poller: polls up to eight NES/SNES shift-register pads in
// parallel through one shared latch/pulse pair, with bit timing derived
// from the system clock.
//
// Ports:
//   clk, rst      system clock, asynchronous active-high reset
//   start         one-cycle frame request, honoured only while idle
//   data_in       active-low serial data, one line per pad
//   latch_out     shared latch to every pad
//   pulse_out     shared shift clock to every pad
//   busy          high from start acceptance through the publish cycle
//   valid         one-cycle strobe when buttons_out updates
//   buttons_out   pad p, bit k at [p*N_BITS+k]; 1 = pressed
//   pressed_out   buttons newly pressed this frame
//
// Optional feature: define NES_POLL_EDGE_EN to build the previous-frame
// register and publish rising edges on pressed_out; otherwise it is tied to 0.
module nes_multi_poller #(
  parameter int unsigned N_PADS  = 2,
  parameter int unsigned N_BITS  = 8,
  parameter int unsigned CLK_DIV = 150
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [N_PADS-1:0]          data_in,
  output logic                       latch_out,
  output logic                       pulse_out,
  output logic                       busy,
  output logic                       valid,
  output logic [N_PADS*N_BITS-1:0]   buttons_out,
  output logic [N_PADS*N_BITS-1:0]   pressed_out
);

  localparam int unsigned W      = N_PADS * N_BITS;
  localparam int unsigned CW     = $clog2(CLK_DIV);
  localparam int unsigned IW     = (N_BITS > 1) ? $clog2(N_BITS) : 1;
  localparam bit          SINGLE = (N_BITS == 1);

  typedef enum logic [2:0] {
    IDLE, LATCH, GAP, PULSE_HI, PULSE_LO, DONE
  } state_t;

  state_t            state;
  logic [N_PADS-1:0] sync1, sync2;
  logic [CW-1:0]     cnt;
  logic [1:0]        tick_n;
  logic [IW-1:0]     idx;
  logic [W-1:0]      sr;
  logic [W-1:0]      sr_next;
  logic              tick_end;
  logic              last_bit;
  logic              load_c;

  assign tick_end = (cnt == CW'(CLK_DIV - 1));
  assign last_bit = (idx == IW'(N_BITS - 1));
  // Final sample of the frame: publish on the same edge that enters DONE.
  assign load_c   = tick_end && (((state == GAP) && SINGLE) ||
                                 ((state == PULSE_LO) && last_bit));

  // Shift register with the current bit of every pad inserted (inverted).
  always_comb begin
    sr_next = sr;
    for (int p = 0; p < int'(N_PADS); p++) begin
      for (int k = 0; k < int'(N_BITS); k++) begin
        if (idx == IW'(k)) sr_next[p*N_BITS + k] = ~sync2[p];
      end
    end
  end

  // Synchronizer, tick timing and frame sequencer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1       <= '0;
      sync2       <= '0;
      state       <= IDLE;
      cnt         <= '0;
      tick_n      <= '0;
      idx         <= '0;
      sr          <= '0;
      latch_out   <= 1'b0;
      pulse_out   <= 1'b0;
      busy        <= 1'b0;
      valid       <= 1'b0;
      buttons_out <= '0;
    end else begin
      sync1 <= data_in;
      sync2 <= sync1;
      valid <= 1'b0;
      // Every state change other than IDLE/DONE happens at end of tick,
      // so wrapping at end of tick doubles as the clear-on-entry.
      cnt   <= (tick_end || state == IDLE || state == DONE) ? '0 : cnt + 1'b1;

      case (state)
        IDLE: begin
          if (start) begin
            state     <= LATCH;
            latch_out <= 1'b1;
            busy      <= 1'b1;
            tick_n    <= '0;
            idx       <= '0;
          end
        end
        LATCH: begin
          if (tick_end) begin
            tick_n <= tick_n + 1'b1;
            if (tick_n == 2'd3) begin
              state     <= GAP;
              latch_out <= 1'b0;
            end
          end
        end
        GAP: begin
          if (tick_end) begin
            sr  <= sr_next;
            idx <= IW'(1);
            if (!SINGLE) begin
              state     <= PULSE_HI;
              pulse_out <= 1'b1;
            end
          end
        end
        PULSE_HI: begin
          if (tick_end) begin
            state     <= PULSE_LO;
            pulse_out <= 1'b0;
          end
        end
        PULSE_LO: begin
          if (tick_end) begin
            sr <= sr_next;
            if (!last_bit) begin
              idx       <= idx + 1'b1;
              state     <= PULSE_HI;
              pulse_out <= 1'b1;
            end
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase

      if (load_c) begin
        state       <= DONE;
        valid       <= 1'b1;
        buttons_out <= sr_next;
      end
    end
  end

`ifdef NES_POLL_EDGE_EN
  logic [W-1:0] prev;

  // Rising-edge detect against the previously published frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev        <= '0;
      pressed_out <= '0;
    end else if (load_c) begin
      pressed_out <= sr_next & ~prev;
      prev        <= sr_next;
    end
  end
`else
  assign pressed_out = '0;
`endif

endmodule
